// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the I/O write scheduler.
// Status word layout and FIFO entry format live here.
package io_ctrl_pkg;

    localparam logic [3:0] STATUS_ADDR = 4'hF;
    localparam int OVF_BIT   = 0;
    localparam int TMO_BIT   = 1;
    localparam int COUNT_LSB = 8;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } io_entry_t;

    function automatic logic [31:0] status_word(
        input logic [7:0] cnt,
        input logic       tmo,
        input logic       ovf
    );
        logic [31:0] w;
        w = '0;
        w[OVF_BIT] = ovf;
        w[TMO_BIT] = tmo;
        w[COUNT_LSB +: 8] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Store queue for the I/O write scheduler.
// Exposes the head and the entry behind it so the bus side can stream back-to-back.
module io_fifo
    import io_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      CLK,
    input  logic      RESET,
    input  logic      push,
    input  logic      pop,
    input  io_entry_t din,
    output io_entry_t dout,
    output io_entry_t dnext,
    output logic [AW:0] count,
    output logic      full,
    output logic      empty
);

    io_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO still accepts a push when a pop frees a slot this cycle
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign dout  = mem[rd_ptr];
    assign dnext = mem[rd_ptr + AW'(1)];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/io_write_scheduler.sv
// Queues core I/O stores and drains them over a valid/ready peripheral bus.
// Optional head-entry timeout is enabled with IO_TIMEOUT_EN.
module io_write_scheduler
    import io_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        io_we,
    input  logic [3:0]  io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [31:0] io_in_data,
    output logic        p_valid,
    output logic [3:0]  p_addr,
    output logic [31:0] p_wdata,
    input  logic        p_ready,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t    state;
    io_entry_t head;
    io_entry_t next;
    io_entry_t din;
    logic [CW-1:0] count;
    logic      full;
    logic      empty;
    logic      push_req;
    logic      stat_wr;
    logic      pop;
    logic      tmo_hit;
    logic      ovf;
    logic      tmo;

    assign push_req = io_we && (io_addr != STATUS_ADDR);
    assign stat_wr  = io_we && (io_addr == STATUS_ADDR);
    assign pop      = p_valid && (p_ready || tmo_hit);
    assign din      = '{addr: io_addr, data: io_wdata};
    assign busy     = !empty;

    io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push_req),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .dnext (next),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign io_rdata = (io_addr == STATUS_ADDR)
                    ? status_word(8'(count), tmo, ovf)
                    : io_in_data;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovf <= 1'b0;
        end else if (push_req && full && !pop) begin
            ovf <= 1'b1;
        end else if (stat_wr && io_wdata[OVF_BIT]) begin
            ovf <= 1'b0;
        end
    end

`ifdef IO_TIMEOUT_EN
    logic [7:0] timer;

    // Drop fires on the cycle the wait would reach TIMEOUT; p_ready wins
    assign tmo_hit = p_valid && !p_ready
                  && (timer == 8'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timer <= '0;
            tmo   <= 1'b0;
        end else begin
            if (pop || !p_valid) begin
                timer <= '0;
            end else begin
                timer <= timer + 8'd1;
            end
            if (tmo_hit) begin
                tmo <= 1'b1;
            end else if (stat_wr && io_wdata[TMO_BIT]) begin
                tmo <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            p_valid <= 1'b0;
            p_addr  <= '0;
            p_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= ISSUE;
                        p_valid <= 1'b1;
                        p_addr  <= head.addr;
                        p_wdata <= head.data;
                    end
                end
                ISSUE: begin
                    if (pop) begin
                        if (count > CW'(1)) begin
                            p_addr  <= next.addr;
                            p_wdata <= next.data;
                        end else begin
                            state   <= IDLE;
                            p_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_write_scheduler.sv
// Scoreboard bench for io_write_scheduler.
// Define IO_TIMEOUT_EN to also exercise the head-entry timeout.
module tb_io_write_scheduler;
    import io_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        io_we = 1'b0;
    logic [3:0]  io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic [31:0] io_in_data = '0;
    logic        p_valid;
    logic [3:0]  p_addr;
    logic [31:0] p_wdata;
    logic        p_ready = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    io_entry_t exp_q [$];

    io_write_scheduler #(.DEPTH(4), .TIMEOUT(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_in_data (io_in_data),
        .p_valid    (p_valid),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_ready    (p_ready),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(
        input string       tag,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(
        input logic [3:0]  a,
        input logic [31:0] d,
        input bit          acc
    );
        io_we = 1'b1;
        io_addr = a;
        io_wdata = d;
        if (acc) exp_q.push_back('{addr: a, data: d});
        cyc();
        io_we = 1'b0;
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        io_addr = STATUS_ADDR;
        #1;
        check(tag, io_rdata, exp);
    endtask

    task automatic drain(input string tag, input int n);
        p_ready = 1'b1;
        repeat (n) cyc();
        p_ready = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_qlen"}, exp_q.size(), 32'd0);
    endtask

    // Bus monitor: every accepted transfer must match the oldest store
    always @(negedge CLK) begin
        if (!RESET && p_valid && p_ready) begin
            if (exp_q.size() == 0) begin
                check("bus_unexpected", 32'd1, 32'd0);
            end else begin
                io_entry_t e;
                e = exp_q.pop_front();
                check("bus_addr", 32'(p_addr), 32'(e.addr));
                check("bus_data", p_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) cyc();
        check("rst_valid", 32'(p_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(p_addr), 32'd0);
        check("rst_wdata", p_wdata, 32'd0);
        rd_status("rst_status", 32'h0);
        RESET = 1'b0;
        io_in_data = 32'h1234_5678;
        io_addr = 4'h3;
        #1;
        check("rd_input", io_rdata, 32'h1234_5678);
        cyc();

        // single store, ready peripheral
        p_ready = 1'b1;
        wr(4'h2, 32'hDEAD_BEEF, 1'b1);
        check("t1_lat", 32'(p_valid), 32'd0);
        cyc();
        check("t1_valid", 32'(p_valid), 32'd1);
        check("t1_addr", 32'(p_addr), 32'h2);
        check("t1_data", p_wdata, 32'hDEAD_BEEF);
        cyc();
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_idle", 32'(p_valid), 32'd0);
        p_ready = 1'b0;

        // five stores into a stalled bus: last overflows
        for (int i = 0; i < 5; i++) begin
            wr(4'(i), 32'hA000_0000 + 32'(i), i < 4);
        end
        rd_status("t2_status", 32'h0000_0401);
        drain("t2_drain", 4);

        // clear both flags
        wr(STATUS_ADDR, 32'h3, 1'b0);
        rd_status("t4_clear", 32'h0);

        // full with a same-cycle pop accepts the push
        for (int i = 6; i < 10; i++) begin
            wr(4'(i), 32'hB000_0000 + 32'(i), 1'b1);
        end
        rd_status("t3_full", 32'h0000_0400);
        p_ready = 1'b1;
        wr(4'hA, 32'hB000_000A, 1'b1);
        p_ready = 1'b0;
        rd_status("t3_keep", 32'h0000_0400);
        wr(4'hB, 32'hB000_000B, 1'b0);
        rd_status("t4_ovf", 32'h0000_0401);
        wr(STATUS_ADDR, 32'h2, 1'b0);
        rd_status("t4_tmo_clr", 32'h0000_0401);
        wr(STATUS_ADDR, 32'h1, 1'b0);
        rd_status("t4_ovf_clr", 32'h0000_0400);
        drain("t3_drain", 4);

`ifdef IO_TIMEOUT_EN
        // head is dropped after 8 stalled cycles
        wr(4'h1, 32'hC000_0001, 1'b1);
        wr(4'h2, 32'hC000_0002, 1'b1);
        check("t5_valid", 32'(p_valid), 32'd1);
        repeat (7) begin
            cyc();
            check("t5_hold", 32'(p_addr), 32'h1);
        end
        cyc();
        void'(exp_q.pop_front());
        check("t5_next_valid", 32'(p_valid), 32'd1);
        check("t5_next_addr", 32'(p_addr), 32'h2);
        check("t5_next_data", p_wdata, 32'hC000_0002);
        rd_status("t5_tmo", 32'h0000_0102);
        drain("t5_drain", 1);
        wr(STATUS_ADDR, 32'h2, 1'b0);
        rd_status("t5_clr", 32'h0);
`endif

        // reset mid-transfer
        for (int i = 3; i < 6; i++) begin
            wr(4'(i), 32'hD000_0000 + 32'(i), 1'b1);
        end
        check("t6_pre_valid", 32'(p_valid), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        exp_q.delete();
        check("t6_valid", 32'(p_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rd_status("t6_status", 32'h0);
        io_in_data = 32'h5A5A_0F0F;
        io_addr = 4'h5;
        #1;
        check("t6_input", io_rdata, 32'h5A5A_0F0F);
        cyc();
        RESET = 1'b0;
        cyc();
        check("t6_after", 32'(p_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
